// File: rtl/flash_dump_manager.sv
// Reads a contiguous (possibly wrapping) flash address range and streams each
// byte to the RS232 transmitter, one flash read and one transmit handshake per byte.
module flash_dump_manager #(
  parameter logic [7:0]  START_ADDR = 8'h00,
  parameter logic [7:0]  LAST_ADDR  = 8'hFF,
  parameter int unsigned FL_TIMEOUT = 1000
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic       START,
  output logic [7:0] FL_ADDR,
  output logic       FL_TRG,
  output logic       FL_FLOW,
  input  logic [7:0] FL_DATA,
  input  logic       FL_STATUS,
  output logic [7:0] RS_DATAIN,
  output logic       RS_TRG_WRITE,
  input  logic       RS_DONE,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_FL, S_WAIT_FL, S_SEND, S_WAIT_RS, S_FINISH
  } state_e;

  localparam logic [15:0] TMO_LAST = 16'(FL_TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  addr_q, rs_data_q;
  logic [15:0] cnt_q;
  logic        fl_trg_q, fl_flow_q, rs_trg_q, busy_q, done_q, err_q;

  logic [7:0]  addr_d;
  logic [15:0] cnt_d;

  assign addr_d = addr_q + 8'd1;
  assign cnt_d  = cnt_q + 16'd1;

  // Pulse outputs are asserted on the edge that enters their state, so
  // FL_TRG, RS_TRG_WRITE and DONE are high exactly while in REQ_FL/SEND/FINISH.
  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state_q   <= S_IDLE;
      addr_q    <= START_ADDR;
      rs_data_q <= 8'h00;
      cnt_q     <= 16'd0;
      fl_trg_q  <= 1'b0;
      fl_flow_q <= 1'b1;
      rs_trg_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      fl_trg_q  <= 1'b0;
      fl_flow_q <= 1'b1;
      rs_trg_q  <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (START) begin
            addr_q   <= START_ADDR;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
            fl_trg_q <= 1'b1;
            state_q  <= S_REQ_FL;
          end
        end
        S_REQ_FL: begin
          cnt_q   <= 16'd0;
          state_q <= S_WAIT_FL;
        end
        S_WAIT_FL: begin
          // Data arriving on the expiry cycle still wins over the timeout.
          if (FL_STATUS) begin
            rs_data_q <= FL_DATA;
            rs_trg_q  <= 1'b1;
            state_q   <= S_SEND;
          end else if (cnt_q == TMO_LAST) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_SEND: state_q <= S_WAIT_RS;
        S_WAIT_RS: begin
          if (RS_DONE) begin
            if (addr_q == LAST_ADDR) begin
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              addr_q   <= addr_d;
              fl_trg_q <= 1'b1;
              state_q  <= S_REQ_FL;
            end
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign FL_ADDR      = addr_q;
  assign FL_TRG       = fl_trg_q;
  assign FL_FLOW      = fl_flow_q;
  assign RS_DATAIN    = rs_data_q;
  assign RS_TRG_WRITE = rs_trg_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign ERR          = err_q;

endmodule
